// File: rtl/mouse_draw_pkg.sv
// Shared definitions for the mouse stroke rasteriser: default geometry,
// FSM state encodings and the coordinate clamp helper.
package mouse_draw_pkg;

  localparam int unsigned DEF_H_RES   = 640;
  localparam int unsigned DEF_V_RES   = 480;
  localparam int unsigned DEF_COORD_W = 10;
  localparam int unsigned DEF_ADDR_W  = 19;

  // Rasteriser FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Saturate a coordinate to the last valid pixel index of an axis of size res.
  function automatic logic [31:0] clamp_coord(input logic [31:0] v, input int unsigned res);
    return (v >= res) ? (res - 32'd1) : v;
  endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham line walker: loads a segment P0->P1, exposes the current point,
// the point after one step and a flag for reaching P1. Steps on `advance`.
module bresenham_stepper
  import mouse_draw_pkg::*;
#(
  parameter int unsigned COORD_W = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [COORD_W-1:0] nxt_x,
  output logic [COORD_W-1:0] nxt_y,
  output logic               last
);

  // err needs one bit of magnitude headroom over a coordinate plus sign
  localparam int unsigned EW = COORD_W + 2;

  logic [COORD_W-1:0]   cur_x_q, cur_y_q, end_x_q, end_y_q;
  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic                 sx_q, sy_q;

  logic [COORD_W-1:0]   adx, ady;
  logic signed [EW-1:0] dx_ld, dy_ld, err_nxt;
  logic signed [EW:0]   e2, neg_dy, dx_ext;
  logic                 step_x, step_y;

  // Absolute deltas of the segment presented on the load inputs
  always_comb begin
    adx   = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    ady   = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    dx_ld = $signed({2'b00, adx});
    dy_ld = $signed({2'b00, ady});
  end

  // One Bresenham step from the current point; e2 is kept one bit wider than err
  always_comb begin
    e2      = {err_q, 1'b0};
    neg_dy  = -{dy_q[EW-1], dy_q};
    dx_ext  = {dx_q[EW-1], dx_q};
    step_x  = (e2 > neg_dy);
    step_y  = (e2 < dx_ext);
    err_nxt = err_q;
    nxt_x   = cur_x_q;
    nxt_y   = cur_y_q;
    if (step_x) begin
      err_nxt = err_nxt - dy_q;
      nxt_x   = sx_q ? (cur_x_q + 1'b1) : (cur_x_q - 1'b1);
    end
    if (step_y) begin
      err_nxt = err_nxt + dx_q;
      nxt_y   = sy_q ? (cur_y_q + 1'b1) : (cur_y_q - 1'b1);
    end
  end

  // Segment registers: loaded at segment start, current point walks on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else if (load) begin
      cur_x_q <= x0;
      cur_y_q <= y0;
      end_x_q <= x1;
      end_y_q <= y1;
      dx_q    <= dx_ld;
      dy_q    <= dy_ld;
      err_q   <= dx_ld - dy_ld;
      sx_q    <= (x1 >= x0);
      sy_q    <= (y1 >= y0);
    end else if (advance) begin
      cur_x_q <= nxt_x;
      cur_y_q <= nxt_y;
      err_q   <= err_nxt;
    end
  end

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign last  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

endmodule

// File: rtl/mouse_stroke_raster.sv
// Mouse stroke rasteriser: joins successive pointer positions while a button
// is held with Bresenham lines and emits one framebuffer write per pixel.
module mouse_stroke_raster
  import mouse_draw_pkg::*;
#(
  parameter int unsigned         H_RES     = DEF_H_RES,
  parameter int unsigned         V_RES     = DEF_V_RES,
  parameter int unsigned         COORD_W   = DEF_COORD_W,
  parameter int unsigned         ADDR_W    = DEF_ADDR_W,
  parameter int unsigned         DATA_W    = 1,
  parameter logic [DATA_W-1:0]   DRAW_VAL  = DATA_W'(1),
  parameter logic [DATA_W-1:0]   ERASE_VAL = DATA_W'(0)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  input  logic               mouse_left,
  input  logic               mouse_right,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy
);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  logic [1:0]         state_q, state_d;
  logic               pen_down_q, pen_down_d;
  logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic [COORD_W-1:0] p0_x_q, p0_x_d, p0_y_q, p0_y_d;
  logic [COORD_W-1:0] p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;

  logic [COORD_W-1:0] cx, cy;
  logic [COORD_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic               any_btn, moved, xfer;
  logic               step_load, step_adv, step_last;

  assign cx      = COORD_W'(clamp_coord(32'(mouse_x), H_RES));
  assign cy      = COORD_W'(clamp_coord(32'(mouse_y), V_RES));
  assign any_btn = mouse_left | mouse_right;
  assign moved   = (cx != last_x_q) || (cy != last_y_q);
  assign xfer    = wr_en_q && wr_ready;

  bresenham_stepper #(
    .COORD_W (COORD_W)
  ) u_stepper (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (step_load),
    .advance (step_adv),
    .x0      (p0_x_q),
    .y0      (p0_y_q),
    .x1      (p1_x_q),
    .y1      (p1_y_q),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .nxt_x   (nxt_x),
    .nxt_y   (nxt_y),
    .last    (step_last)
  );

  // Next-state logic: pen tracking in IDLE, segment sequencing and output registers
  always_comb begin
    state_d    = state_q;
    pen_down_d = pen_down_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    p0_x_d     = p0_x_q;
    p0_y_d     = p0_y_q;
    p1_x_d     = p1_x_q;
    p1_y_d     = p1_y_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    step_load  = 1'b0;
    step_adv   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!any_btn) begin
          pen_down_d = 1'b0;
          last_x_d   = cx;
          last_y_d   = cy;
        end else if (!pen_down_q || moved) begin
          // A fresh touch draws a single pixel; otherwise continue from the last endpoint
          p0_x_d    = pen_down_q ? last_x_q : cx;
          p0_y_d    = pen_down_q ? last_y_q : cy;
          p1_x_d    = cx;
          p1_y_d    = cy;
          wr_data_d = mouse_left ? DRAW_VAL : ERASE_VAL;
          busy_d    = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        step_load  = 1'b1;
        pen_down_d = 1'b1;
        wr_en_d    = 1'b1;
        wr_addr_d  = pix_addr(p0_x_q, p0_y_q);
        state_d    = ST_DRAW;
      end
      ST_DRAW: begin
        if (xfer) begin
          if (step_last) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            step_adv  = 1'b1;
            wr_addr_d = pix_addr(nxt_x, nxt_y);
          end
        end
      end
      ST_DONE: begin
        last_x_d = p1_x_q;
        last_y_d = p1_y_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any segment in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pen_down_q <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      p0_x_q     <= '0;
      p0_y_q     <= '0;
      p1_x_q     <= '0;
      p1_y_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= ERASE_VAL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pen_down_q <= pen_down_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      p0_x_q     <= p0_x_d;
      p0_y_q     <= p0_y_d;
      p1_x_q     <= p1_x_d;
      p1_y_q     <= p1_y_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

  // cur_x/cur_y are kept for visibility of the walker position
  logic unused_cur;
  assign unused_cur = ^{cur_x, cur_y};

endmodule

// File: doc/mouse_stroke_raster.md
Name: mouse_stroke_raster

Overview:
Turns sampled mouse position and button state into a continuous stroke of framebuffer pixel writes.
- Each new position while a button is held is joined to the previous endpoint by a Bresenham line, one pixel per accepted write.
- Sits between the mouse decoder and the canvas framebuffer write port.
- Generalises the earlier single-pixel plotter: parametrised resolution and pixel width, draw/erase colours, write back-pressure, and coordinate clamping.

Parameters:
- H_RES, 640, canvas width in pixels.
- V_RES, 480, canvas height in pixels.
- COORD_W, 10, width of the x/y coordinate inputs.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DATA_W, 1, pixel data width.
- DRAW_VAL, 1, pixel value written on a left-button stroke.
- ERASE_VAL, 0, pixel value written on a right-button stroke.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mouse_x  in  COORD_W  current pointer x.
- mouse_y  in  COORD_W  current pointer y.
- mouse_left  in  1  left button held (draw).
- mouse_right  in  1  right button held (erase).
- wr_ready  in  1  framebuffer accepts a write this cycle.
- wr_en  out  1  write request valid.
- wr_addr  out  ADDR_W  pixel address, y*H_RES + x.
- wr_data  out  DATA_W  pixel value.
- busy  out  1  a segment is being rasterised.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. On reset, wr_en=0, wr_addr=0, wr_data=ERASE_VAL, busy=0, state=IDLE, pen_down=0, last endpoint=(0,0).
- Input clamping: x>=H_RES becomes H_RES-1; y>=V_RES becomes V_RES-1. Clamping applies before any use.
- Mode: left has priority. With both buttons held, wr_data=DRAW_VAL. Mode is latched at segment start and held for the whole segment.
- Write handshake: a write transfers when wr_en && wr_ready.
  - While wr_en=1 && wr_ready=0, wr_addr and wr_data stay stable.
  - Rasteriser state does not advance until the transfer.
  - All outputs are registered.
- State IDLE:
  - No button held: pen_down=0, last endpoint tracks the clamped position every cycle.
  - Button held && pen_down=0 (pen touch): latch P0=P1=current position, go to START.
  - Button held && pen_down=1 && position != last: latch P0=last, P1=current, go to START.
  - Button held && position == last: stay in IDLE, no writes.
- State START (1 cycle):
  - Compute dx=|x1-x0|, dy=|y1-y0|, sx, sy, err=dx-dy. err is signed, COORD_W+2 bits.
  - Set pen_down=1, busy=1; load the current point=P0. Go to DRAW.
- State DRAW:
  - Present the current point with wr_en=1.
  - On transfer: if the current point == P1, go to DONE.
  - Otherwise take one Bresenham step: e2=2*err; if e2>-dy then err-=dy, x+=sx; if e2<dx then err+=dx, y+=sy.
  - Sustained rate: one pixel per cycle while wr_ready=1.
  - P0 is written; a segment of N pixels issues exactly N writes.
- State DONE (1 cycle): wr_en=0, busy=0, last=P1, go to IDLE.
- Chained segments share an endpoint, so that pixel is written twice. This is acceptable and idempotent.
- Mouse movement during START/DRAW/DONE is ignored. The new position is picked up in IDLE as the next segment from P1, so the stroke has no gaps.
- Button released mid-segment: the segment completes with its latched mode. In IDLE, pen_down clears.
- Address: y*H_RES + x, computed in ADDR_W bits and registered together with the point. No multiplier-by-division paths.
- Mid-operation reset aborts the segment immediately; wr_en=0 asynchronously.

Decomposition:
- Shared package mouse_draw_pkg holds:
  - the state enum (IDLE, START, DRAW, DONE);
  - the default H_RES/V_RES/COORD_W/ADDR_W constants;
  - a clamp function.
- One natural sub-module: bresenham_stepper. It covers the START/DRAW arithmetic: load P0/P1, step on an advance strobe, and a last-point flag. The top module owns mode, pen tracking, the handshake and address generation.

Test Plan:
- Reset, then left press at (10,20) with no motion -> exactly one write, addr 12810, data 1; busy pulses.
- Left held, move (10,20)->(15,20), wr_ready=1 -> 6 writes at addrs 12810..12815 on consecutive cycles.
- Left held, move (0,0)->(3,7) -> 8 writes; y strictly +1 per write; final addr 7*640+3=4483.
- Right held, segment of 4 pixels, wr_ready toggling 1,0,0,1,... -> addr/data stable while stalled; exactly 4 transfers, data 0.
- Move to (700,500) with left held -> clamped endpoint (639,479); final addr 307199, never out of range.
- Release button mid-segment, then assert rst_n=0 during the next segment -> first segment completes, second aborts with wr_en=0 immediately; after reset, first press writes a single pixel.
